prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial PRBS/LFSR sequence checker: the receive-side counterpart of the team's 8-bit LFSR pattern generator.
- Takes the generator's serial output bit stream, self-synchronises a local LFSR to it, declares lock, then counts bit errors against the predicted sequence.
- Error count is presented on an 8-bit output bus. A hold input freezes that bus, mirroring the generator's output-capture mux.

Parameters:
- WIDTH, 8, LFSR length in bits.
- TAPS, 8'hB8, feedback tap mask; predicted bit = XOR-reduce(sr & TAPS). Default is x^8+x^6+x^5+x^4+1.
- LOCK_LEN, 16, consecutive correct predictions required to enter LOCKED.
- WINDOW, 32, valid bits per loss-of-lock evaluation window.
- LOSS_THRESH, 4, errors within one window that force return to SEARCH.

Ports:
- clock  input  1  Single clock; all state updates on the rising edge.
- reset_n  input  1  Asynchronous reset, active-low.
- bit_in  input  1  Received serial bit; sampled only when bit_valid=1.
- bit_valid  input  1  Qualifies bit_in for one clock.
- clear_cnt  input  1  Synchronous clear of the error counter.
- hold  input  1  1 = freeze err_count output; 0 = track the internal count.
- locked  output  1  1 while in LOCKED state.
- err_pulse  output  1  One-cycle pulse per detected error while LOCKED.
- err_count  output  8  Saturating error count; internal value, or held snapshot when hold=1.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=SEARCH.
  - sr=0, fill=0, match_cnt=0, win_cnt=0, win_err=0, internal count=0.
  - locked=0, err_pulse=0, err_count=0.
- Cycles with bit_valid=0 change nothing except:
  - err_pulse returns to 0.
  - clear_cnt and hold still act.
- pred = ^(sr & TAPS); mism = bit_in ^ pred. All outputs are registered, so effects are visible the cycle after the sampling edge.
- SEARCH, on each valid bit:
  - sr <= {sr[WIDTH-2:0], bit_in} (self-synchronising load).
  - While fill < WIDTH: fill++, no comparison.
  - Otherwise, if mism=1 or sr==0 (lock-up state is never a valid PRBS state): match_cnt <= 0.
  - Otherwise match_cnt++. When a match occurs with match_cnt == LOCK_LEN-1: go to LOCKED, locked <= 1, win_cnt <= 0, win_err <= 0.
  - Consequence: an error-free stream locks on exactly valid bit WIDTH+LOCK_LEN (24 with defaults).
  - err_pulse stays 0 and the counter does not increment in SEARCH.
- LOCKED, on each valid bit:
  - sr <= {sr[WIDTH-2:0], pred} (free-running local generator; received errors do not propagate).
  - err_pulse <= mism.
  - Internal count increments on mism, saturating at 255.
  - win_cnt counts 0..WINDOW-1 and wraps. win_err increments on mism.
- Loss of lock:
  - If win_err+mism reaches LOSS_THRESH: go to SEARCH, locked <= 0, fill <= 0, match_cnt <= 0. The err_pulse for that final error is still emitted.
  - The internal count is retained across loss of lock.
- Window end (win_cnt == WINDOW-1):
  - The current bit's mism is evaluated against the threshold first.
  - win_err is then reset to 0.
- clear_cnt=1: internal count <= 0. Clear wins over a simultaneous increment.
- Output hold:
  - hold=0: err_count <= internal count each cycle.
  - hold=1: err_count keeps its value.
  - Internal count continues regardless of hold.
- reset_n asserted mid-stream: immediate return to the reset state; no partial lock survives.

Test Plan:
- Reset, then feed an error-free TAPS=8'hB8 sequence (any nonzero seed, bit_valid every cycle) -> locked=0 through bit 23; locked=1 the cycle after bit 24; err_count=0.
- Locked, flip 3 bits within one 32-bit window -> 3 err_pulse cycles, err_count=3, locked stays 1.
- Locked, flip 4 bits within one window -> 4th err_pulse emitted, locked=0 next cycle, err_count=4; clean stream resumes -> relock after 24 more valid bits.
- Stream of all zeros, 100 valid bits -> locked never asserts.
- Locked with errors spread so each window has at most 3 (e.g. 1 per 16 bits) for 300 errors -> err_count saturates at 255; clear_cnt pulse -> 0; clear_cnt coincident with an error -> 0.
- err_count=5, assert hold, inject 2 errors -> err_count reads 5; release hold -> 7 next cycle; reset_n low mid-LOCKED -> locked=0 and err_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises a local LFSR to the received stream,
// declares lock after a run of correct predictions, then counts bit errors.
module prbs_checker #(
   parameter int              WIDTH       = 8,
   parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
   parameter int              LOCK_LEN    = 16,
   parameter int              WINDOW      = 32,
   parameter int              LOSS_THRESH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       bit_in,
   input  logic       bit_valid,
   input  logic       clear_cnt,
   input  logic       hold,
   output logic       locked,
   output logic       err_pulse,
   output logic [7:0] err_count
);

   localparam int FW = $clog2(WIDTH + 1);
   localparam int MW = $clog2(LOCK_LEN + 1);
   localparam int WW = $clog2(WINDOW + 1);
   localparam int EW = $clog2(LOSS_THRESH + 1);

   localparam logic [FW-1:0] FILL_FULL  = FW'(WIDTH);
   localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_LEN - 1);
   localparam logic [WW-1:0] WIN_LAST   = WW'(WINDOW - 1);
   localparam logic [EW-1:0] LOSS_LIM   = EW'(LOSS_THRESH);

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [MW-1:0]    match_q, match_d;
   logic [WW-1:0]    win_cnt_q, win_cnt_d;
   logic [EW-1:0]    win_err_q, win_err_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             locked_q, locked_d;
   logic             err_pulse_q, err_pulse_d;
   logic [7:0]       err_count_q, err_count_d;

   logic             pred;
   logic             mism;
   logic [EW-1:0]    err_total;

   assign pred      = ^(sr_q & TAPS);
   assign mism      = bit_in ^ pred;
   // Errors in the current window including this bit; bounded by LOSS_THRESH.
   assign err_total = win_err_q + EW'(mism);

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_cnt_d   = win_cnt_q;
      win_err_d   = win_err_q;
      cnt_d       = cnt_q;
      locked_d    = locked_q;
      err_pulse_d = 1'b0;

      if (bit_valid) begin
         case (state_q)
            SEARCH: begin
               sr_d = {sr_q[WIDTH-2:0], bit_in};
               if (fill_q < FILL_FULL) begin
                  fill_d = fill_q + 1'b1;
               end else if (mism || (sr_q == '0)) begin
                  match_d = '0;
               end else if (match_q == MATCH_LAST) begin
                  state_d   = LOCKED;
                  locked_d  = 1'b1;
                  match_d   = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  match_d = match_q + 1'b1;
               end
            end

            LOCKED: begin
               // Free-run on our own prediction so received errors stay isolated.
               sr_d        = {sr_q[WIDTH-2:0], pred};
               err_pulse_d = mism;
               if (mism && (cnt_q != 8'hFF)) begin
                  cnt_d = cnt_q + 8'd1;
               end
               win_cnt_d = (win_cnt_q == WIN_LAST) ? '0 : win_cnt_q + 1'b1;
               win_err_d = (win_cnt_q == WIN_LAST) ? '0 : err_total;
               if (err_total >= LOSS_LIM) begin
                  state_d  = SEARCH;
                  locked_d = 1'b0;
                  fill_d   = '0;
                  match_d  = '0;
               end
            end

            default: begin
               state_d = SEARCH;
            end
         endcase
      end

      if (clear_cnt) begin
         cnt_d = 8'd0;
      end

      err_count_d = hold ? err_count_q : cnt_d;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= SEARCH;
         sr_q        <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_cnt_q   <= '0;
         win_err_q   <= '0;
         cnt_q       <= 8'd0;
         locked_q    <= 1'b0;
         err_pulse_q <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_cnt_q   <= win_cnt_d;
         win_err_q   <= win_err_d;
         cnt_q       <= cnt_d;
         locked_q    <= locked_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: a reference model queues the expected
// outputs for every driven cycle, popped and compared after the clock edge.
module tb_prbs_checker;

   localparam logic [7:0] TAPS = 8'hB8;

   logic       clock     = 1'b0;
   logic       reset_n   = 1'b1;
   logic       bit_in    = 1'b0;
   logic       bit_valid = 1'b0;
   logic       clear_cnt = 1'b0;
   logic       hold      = 1'b0;
   logic       locked;
   logic       err_pulse;
   logic [7:0] err_count;

   prbs_checker dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .clear_cnt (clear_cnt),
      .hold      (hold),
      .locked    (locked),
      .err_pulse (err_pulse),
      .err_count (err_count)
   );

   always #5 clock = ~clock;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [9:0] exp_q[$];
   logic [7:0] g_sr;
   int         pulses_seen;
   bit         gaps_on;
   bit         seen_lock;

   // reference model state
   bit         m_lock;
   bit         m_pulse;
   logic [7:0] m_sr;
   int         m_fill, m_match, m_win, m_werr;
   logic [7:0] m_cnt, m_ecnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lock = 0; m_pulse = 0; m_sr = 8'h00;
      m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_cnt = 8'h00; m_ecnt = 8'h00;
   endtask

   task automatic model_step(input bit bv, input bit bi, input bit clr, input bit hld);
      logic [7:0] old;
      bit pred, mism;
      m_pulse = 0;
      if (bv) begin
         old  = m_sr;
         pred = ^(old & TAPS);
         mism = bi ^ pred;
         if (!m_lock) begin
            m_sr = {old[6:0], bi};
            if (m_fill < 8) m_fill++;
            else if (mism || old == 8'h00) m_match = 0;
            else if (m_match == 15) begin
               m_lock = 1; m_win = 0; m_werr = 0; m_match = 0;
            end else m_match++;
         end else begin
            m_sr    = {old[6:0], pred};
            m_pulse = mism;
            if (mism && m_cnt != 8'hFF) m_cnt++;
            if (m_werr + int'(mism) >= 4) begin
               m_lock = 0; m_fill = 0; m_match = 0;
            end
            if (m_win == 31) begin
               m_werr = 0; m_win = 0;
            end else begin
               m_werr = m_werr + int'(mism); m_win++;
            end
         end
      end
      if (clr) m_cnt = 8'h00;
      if (!hld) m_ecnt = m_cnt;
   endtask

   task automatic cycle(input bit bv, input bit bi, input bit clr, input bit hld);
      logic [9:0] g, e;
      @(negedge clock);
      bit_valid = bv; bit_in = bi; clear_cnt = clr; hold = hld;
      model_step(bv, bi, clr, hld);
      exp_q.push_back({m_lock, m_pulse, m_ecnt});
      @(posedge clock);
      #1;
      g = {locked, err_pulse, err_count};
      e = exp_q.pop_front();
      check("cycle", g, e);
      if (err_pulse) pulses_seen++;
   endtask

   task automatic send_bit(input bit flip, input bit clr, input bit hld);
      bit b;
      if (gaps_on && $urandom_range(0, 3) == 0) cycle(0, 1'($urandom_range(0, 1)), 0, hld);
      b    = ^(g_sr & TAPS);
      g_sr = {g_sr[6:0], b};
      cycle(1, b ^ flip, clr, hld);
   endtask

   task automatic do_reset(input logic [7:0] seed);
      @(negedge clock);
      reset_n = 0; bit_valid = 0; clear_cnt = 0; hold = 0;
      model_reset();
      g_sr = seed;
      @(negedge clock);
      reset_n = 1;
   endtask

   task automatic acquire(input string tag);
      for (int i = 1; i <= 24; i++) begin
         send_bit(0, 0, 0);
         if (i == 23) check({tag, "_b23"}, locked, 0);
      end
      check({tag, "_b24"}, locked, 1);
   endtask

   initial begin
      gaps_on = 0;
      model_reset();
      g_sr = 8'h01;
      #1 reset_n = 0;
      #1;
      check("rst_locked", locked, 0);
      check("rst_pulse", err_pulse, 0);
      check("rst_cnt", err_count, 0);
      @(negedge clock);
      reset_n = 1;

      $display("[tb] clean acquisition, seed 0x01");
      acquire("lock1");
      check("cnt_clean", err_count, 0);

      $display("[tb] 3 errors in one window");
      gaps_on = 1;
      pulses_seen = 0;
      for (int p = 0; p < 32; p++) send_bit(p == 4 || p == 10 || p == 20, 0, 0);
      check("pulses3", pulses_seen, 3);
      check("cnt3", err_count, 3);
      check("lock_kept", locked, 1);

      $display("[tb] 4 errors in one window, loss and relock");
      cycle(0, 0, 1, 0);
      check("clr_idle", err_count, 0);
      pulses_seen = 0;
      for (int p = 0; p < 8; p++) begin
         send_bit(p % 2 == 1, 0, 0);
         if (p == 5) check("lock_pre4", locked, 1);
      end
      check("pulse4", err_pulse, 1);
      check("lost", locked, 0);
      check("cnt4", err_count, 4);
      check("pulses4", pulses_seen, 4);
      acquire("relock");

      $display("[tb] all-zero stream");
      gaps_on = 0;
      do_reset(8'h5A);
      seen_lock = 0;
      for (int i = 0; i < 100; i++) begin
         cycle(1, 0, 0, 0);
         if (locked) seen_lock = 1;
      end
      check("zeros_nolock", seen_lock, 0);

      $display("[tb] saturation, clear and clear-vs-error");
      do_reset(8'hC3);
      gaps_on = 1;
      acquire("lock2");
      for (int k = 0; k < 300; k++)
         for (int j = 0; j < 16; j++) send_bit(j == 15, 0, 0);
      check("sat255", err_count, 255);
      check("sat_lock", locked, 1);
      cycle(0, 0, 1, 0);
      check("clr_sat", err_count, 0);
      send_bit(1, 1, 0);
      check("clr_err_pulse", err_pulse, 1);
      check("clr_err_cnt", err_count, 0);
      for (int j = 0; j < 15; j++) send_bit(0, 0, 0);

      $display("[tb] hold freezes output");
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < 16; j++) send_bit(j == 15, 0, 0);
      check("cnt5", err_count, 5);
      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 16; j++) send_bit(j == 15, 0, 1);
      check("hold5", err_count, 5);
      cycle(0, 0, 0, 0);
      check("rel7", err_count, 7);
      check("lock_hold", locked, 1);

      $display("[tb] asynchronous reset while locked");
      #2 reset_n = 0;
      #1;
      check("arst_locked", locked, 0);
      check("arst_cnt", err_count, 0);
      check("arst_pulse", err_pulse, 0);
      model_reset();
      @(negedge clock);
      reset_n = 1;
      g_sr = 8'h33;
      for (int i = 0; i < 10; i++) send_bit(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
